// File: rtl/huc_timer.sv
// huc_timer: prescaled 7-bit down-counting interval timer with level interrupt
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   CET_n    in   chip enable from MMU decode, active low
//   addr0    in   register select: 0 = reload, 1 = control (bit 0 = enable)
//   wr_en    in   single-cycle write strobe
//   rd_en    in   single-cycle read strobe
//   d_in     in   [7:0] write data
//   d_out    out  [7:0] registered read data, {1'b0, count}
//   tiq_ack  in   interrupt acknowledge pulse
//   tiq      out  interrupt request, active-high level
module huc_timer #(
    parameter int PRESCALE = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       CET_n,
    input  logic       addr0,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    input  logic       tiq_ack,
    output logic       tiq
);
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    logic [6:0]    r_reload;
    logic [6:0]    r_count;
    logic          r_enable;
    logic [PW-1:0] r_pre;
    logic          r_tiq;
    logic [7:0]    r_dout;
    logic          w_wr;
    logic          w_rd;
    logic          w_ctl;
    logic          w_start;
    logic          w_run;
    logic          w_tick;
    logic          w_uflow;
    logic          w_unused;
    assign w_wr     = wr_en & ~CET_n;
    assign w_rd     = rd_en & ~CET_n;
    assign w_ctl    = w_wr & addr0;
    // only a 0->1 enable transition restarts the countdown
    assign w_start  = w_ctl & d_in[0] & ~r_enable;
    // any control write suspends prescaler activity for that edge
    assign w_run    = r_enable & ~w_ctl;
    assign w_tick   = w_run & (r_pre == PMAX);
    assign w_uflow  = w_tick & (r_count == 7'd0);
    assign w_unused = &{1'b0, d_in[7:1]};
    assign d_out    = r_dout;
    assign tiq      = r_tiq;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reload <= '0;
            r_count  <= '0;
            r_enable <= 1'b0;
            r_pre    <= '0;
            r_tiq    <= 1'b0;
            r_dout   <= '0;
        end else begin
            if (w_wr & ~addr0) r_reload <= d_in[6:0];
            if (w_ctl) r_enable <= d_in[0];
            if (w_start) begin
                r_count <= r_reload;
                r_pre   <= '0;
            end else if (w_run) begin
                r_pre <= w_tick ? '0 : r_pre + PW'(1);
                if (w_tick) r_count <= w_uflow ? r_reload : r_count - 7'd1;
            end
            // underflow has priority over a coincident acknowledge
            if (w_uflow) r_tiq <= 1'b1;
            else if (tiq_ack) r_tiq <= 1'b0;
            // sampled before this edge's write or tick takes effect
            if (w_rd) r_dout <= {1'b0, r_count};
        end
    end
endmodule

// File: tb/tb_huc_timer.sv
// tb_huc_timer: directed self-checking bench for huc_timer
module tb_huc_timer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       CET_n = 1'b1;
    logic       addr0 = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       tiq_ack = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic [7:0] d_out;
    logic [7:0] d_out1;
    logic       tiq;
    logic       tiq1;
    int         n_chk = 0;
    int         n_err = 0;
    int         first;

    always #5 clk = ~clk;

    huc_timer #(.PRESCALE(4)) u0 (
        .clk(clk), .reset_n(reset_n), .CET_n(CET_n), .addr0(addr0),
        .wr_en(wr_en), .rd_en(rd_en), .d_in(d_in), .d_out(d_out),
        .tiq_ack(tiq_ack), .tiq(tiq)
    );

    huc_timer #(.PRESCALE(16)) u1 (
        .clk(clk), .reset_n(reset_n), .CET_n(CET_n), .addr0(addr0),
        .wr_en(wr_en), .rd_en(rd_en), .d_in(d_in), .d_out(d_out1),
        .tiq_ack(tiq_ack), .tiq(tiq1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic a, input logic [7:0] d, input logic ce_n);
        CET_n = ce_n;
        wr_en = 1'b1;
        addr0 = a;
        d_in  = d;
        cyc(1);
        wr_en = 1'b0;
        CET_n = 1'b1;
    endtask

    task automatic rd(input logic ce_n);
        CET_n = ce_n;
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
        CET_n = 1'b1;
    endtask

    initial begin
        #3;
        check("rst_dout", d_out, 0);
        check("rst_tiq", tiq, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rd(1'b0);
        check("rst_count", d_out, 0);
        cyc(3);
        check("idle_tiq", tiq, 0);

        // reload=3: count 3,3,3,3,2,... and tiq exactly 16 edges after start
        wr(1'b0, 8'd3, 1'b0);
        wr(1'b1, 8'd1, 1'b0);
        CET_n = 1'b0;
        rd_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cyc(1);
            check("t31_cnt", d_out, 3 - (i - 1) / 4);
            check("t31_tiq", tiq, (i == 16) ? 1 : 0);
        end
        rd_en = 1'b0;
        CET_n = 1'b1;
        tiq_ack = 1'b1;
        cyc(1);
        tiq_ack = 1'b0;
        check("t31_ack", tiq, 0);
        wr(1'b1, 8'd0, 1'b0);

        // reload=0: underflow every 4 edges, set beats coincident ack
        wr(1'b0, 8'd0, 1'b0);
        wr(1'b1, 8'd1, 1'b0);
        cyc(4);
        check("t32_uf1", tiq, 1);
        tiq_ack = 1'b1;
        cyc(1);
        tiq_ack = 1'b0;
        check("t32_ack1", tiq, 0);
        cyc(2);
        check("t32_pre_uf2", tiq, 0);
        tiq_ack = 1'b1;
        cyc(1);
        check("t32_setwins", tiq, 1);
        cyc(1);
        tiq_ack = 1'b0;
        check("t32_ack2", tiq, 0);
        wr(1'b1, 8'd0, 1'b0);

        // freeze at count=2, then restart from reload with prescaler at 0
        wr(1'b0, 8'd3, 1'b0);
        wr(1'b1, 8'd1, 1'b0);
        cyc(5);
        wr(1'b1, 8'd0, 1'b0);
        cyc(20);
        rd(1'b0);
        check("t33_frozen", d_out, 8'h02);
        check("t33_tiq", tiq, 0);
        wr(1'b1, 8'd1, 1'b0);
        CET_n = 1'b0;
        rd_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc(1);
            check("t33_restart", d_out, (i < 5) ? 3 : 2);
        end
        rd_en = 1'b0;
        CET_n = 1'b1;
        wr(1'b1, 8'd0, 1'b0);

        // reload=5 written mid-count only applies at the next underflow
        wr(1'b1, 8'd1, 1'b0);
        wr(1'b0, 8'd5, 1'b0);
        CET_n = 1'b0;
        rd_en = 1'b1;
        for (int i = 2; i <= 17; i++) begin
            cyc(1);
            check("t34_cnt", d_out, (i <= 16) ? 3 - (i - 1) / 4 : 5);
            if (i == 16) check("t34_tiq", tiq, 1);
        end
        rd_en = 1'b0;
        CET_n = 1'b1;
        tiq_ack = 1'b1;
        cyc(1);
        tiq_ack = 1'b0;
        check("t34_ack", tiq, 0);
        wr(1'b1, 8'd0, 1'b0);

        // accesses with CET_n=1 are ignored
        rd(1'b0);
        check("t35_rd5", d_out, 5);
        wr(1'b0, 8'd2, 1'b0);
        wr(1'b1, 8'd1, 1'b1);
        cyc(8);
        wr(1'b0, 8'h7f, 1'b1);
        rd(1'b0);
        check("t35_nostart", d_out, 5);
        wr(1'b1, 8'd1, 1'b0);
        rd(1'b1);
        check("t35_nord", d_out, 5);
        rd(1'b0);
        check("t35_reload", d_out, 2);
        wr(1'b1, 8'd0, 1'b1);
        cyc(5);
        rd(1'b0);
        check("t35_running", d_out, 0);
        cyc(3);
        check("t35_uf", tiq, 1);
        rd(1'b0);
        check("t35_cnt2", d_out, 2);
        check("t35_tiq_hold", tiq, 1);

        // asynchronous reset mid-count
        #2;
        reset_n = 1'b0;
        #1;
        check("t35_arst_dout", d_out, 0);
        check("t35_arst_tiq", tiq, 0);
        cyc(2);
        reset_n = 1'b1;
        cyc(40);
        check("t35_stopped_tiq", tiq, 0);
        rd(1'b0);
        check("t35_stopped_cnt", d_out, 0);
        wr(1'b1, 8'd1, 1'b0);
        rd(1'b0);
        check("t35_reload0", d_out, 0);
        wr(1'b1, 8'd0, 1'b0);

        // long period: PRESCALE=16, reload=127 -> 128*16 = 2048 edges
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        wr(1'b0, 8'd127, 1'b0);
        wr(1'b1, 8'd1, 1'b0);
        first = -1;
        for (int i = 1; i <= 3000 && first < 0; i++) begin
            cyc(1);
            if (tiq1) first = i;
        end
        check("t36_period", first, 2048);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
